// File: rtl/duck_shot_controller.sv
// duck_shot_controller
//   Sequences one shooting round of the duck hunt game: turns trigger presses
//   into single clicks, waits out the hit-detector latency, samples the
//   detector once per shot, keeps the ammunition count and the saturating
//   score, and freezes the duck for a number of frames after a hit.
//
// Ports
//   clk              system (pixel) clock
//   rst_n            asynchronous active-low reset
//   new_frame        one-cycle pulse per video frame
//   round_start      one-cycle pulse, arms a new round from IDLE or DONE
//   mouse_left       left-button level, synchronous to clk
//   mouse_on_target  registered hit-detector output
//   shots_left       remaining shots in the current round
//   duck_hit         one-cycle pulse when a shot hits
//   duck_freeze      high while the duck is held after a hit
//   shot_fired       one-cycle pulse for every accepted shot
//   round_over       high while the round is finished
//   round_won        valid while round_over is high, 1 = duck was hit
//   score            accumulated score, kept across rounds
module duck_shot_controller #(
    parameter int SHOTS_PER_ROUND = 3,
    parameter int DETECT_LATENCY  = 1,
    parameter int HIT_HOLD_FRAMES = 30,
    parameter int POINTS_PER_HIT  = 100,
    parameter int SCORE_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_frame,
    input  logic               round_start,
    input  logic               mouse_left,
    input  logic               mouse_on_target,
    output logic [2:0]         shots_left,
    output logic               duck_hit,
    output logic               duck_freeze,
    output logic               shot_fired,
    output logic               round_over,
    output logic               round_won,
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WAIT_DET,
        S_EVAL,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [2:0] SHOTS_INIT = 3'(SHOTS_PER_ROUND);
    localparam logic [2:0] LAT_INIT   = 3'(DETECT_LATENCY);
    localparam logic [7:0] HOLD_INIT  = 8'(HIT_HOLD_FRAMES);

    state_t     state;
    logic       mouse_left_q;
    logic [2:0] lat_cnt;
    logic [7:0] frame_cnt;
    logic       click;

    // A held button produces exactly one click on its rising edge.
    assign click = mouse_left & ~mouse_left_q;

    // Add one hit worth of points, clamping at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W+1)'(POINTS_PER_HIT);
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            mouse_left_q <= 1'b0;
            lat_cnt      <= '0;
            frame_cnt    <= '0;
            shots_left   <= '0;
            duck_hit     <= 1'b0;
            duck_freeze  <= 1'b0;
            shot_fired   <= 1'b0;
            round_over   <= 1'b0;
            round_won    <= 1'b0;
            score        <= '0;
        end else begin
            mouse_left_q <= mouse_left;
            shot_fired   <= 1'b0;
            duck_hit     <= 1'b0;

            case (state)
                // A click arriving together with round_start is not a shot:
                // clicks are only accepted once ARMED.
                S_IDLE, S_DONE: begin
                    if (round_start) begin
                        state      <= S_ARMED;
                        shots_left <= SHOTS_INIT;
                        round_won  <= 1'b0;
                        round_over <= 1'b0;
                    end
                end

                // The EVAL cycle lands DETECT_LATENCY cycles after the click
                // cycle; latencies 0 and 1 both go straight to EVAL.
                S_ARMED: begin
                    if (click) begin
                        shot_fired <= 1'b1;
                        shots_left <= shots_left - 3'd1;
                        lat_cnt    <= LAT_INIT;
                        state      <= (DETECT_LATENCY <= 1) ? S_EVAL : S_WAIT_DET;
                    end
                end

                S_WAIT_DET: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd2) begin
                        state <= S_EVAL;
                    end
                end

                // shots_left already holds the post-shot count here.
                S_EVAL: begin
                    if (mouse_on_target) begin
                        duck_hit    <= 1'b1;
                        score       <= sat_add(score);
                        frame_cnt   <= HOLD_INIT;
                        duck_freeze <= 1'b1;
                        state       <= S_HOLD;
                    end else if (shots_left == 3'd0) begin
                        round_over <= 1'b1;
                        round_won  <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        state <= S_ARMED;
                    end
                end

                // Leaving on the frame that would take the counter to zero.
                S_HOLD: begin
                    if (new_frame) begin
                        if (frame_cnt == 8'd1) begin
                            duck_freeze <= 1'b0;
                            round_over  <= 1'b1;
                            round_won   <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            frame_cnt <= frame_cnt - 8'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
